router_port_arbiter: RTL and testbench
======================================

Name: router_port_arbiter

Overview:
Round-robin arbiter for one router output port. It shares the port between five sources: the NORTH, SOUTH, EAST and WEST input ports, and the local cache bank. One instance sits in front of each of the five router outputs and drives the crossbar mux select. A grant is held for a bounded burst, and the next grant is issued without a bubble cycle.

Parameters:
NUM_REQ, 5, number of requesters; bit order 0=NORTH 1=SOUTH 2=EAST 3=WEST 4=LOCAL
MAX_BURST, 4, max transfers per grant before forced release; legal range 1..15
IDX_WIDTH, 3, width of grantIndex; must satisfy 2^IDX_WIDTH >= NUM_REQ

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low; asserted when low, sampled on the rising edge of clk
request  input  NUM_REQ  per-source request; held high while the source has a flit for this port
portEnable  input  1  downstream ready for this output port (same meaning as the router portEnable_*)
grant  output  NUM_REQ  one-hot grant; all zero when idle
grantValid  output  1  OR of grant
grantIndex  output  IDX_WIDTH  binary index of the granted source; 0 when idle
transferValid  output  1  combinational: grantValid & request[grantIndex] & portEnable; one flit moves this cycle
busy  output  1  FSM in GRANT state

Behaviour:
- Registered state: FSM {IDLE, GRANT}, grant register, round-robin pointer ptr (IDX_WIDTH bits), burst counter cnt (4 bits).
- Reset (reset==0 at a clk edge):
  - grant=0, grantValid=0, grantIndex=0, busy=0, ptr=0, cnt=0, state=IDLE.
  - Reset mid-burst drops the grant at that edge; the in-flight flit is not transferred.
- Arbitration function: search request starting at ptr, ascending with wrap modulo NUM_REQ; the first set bit wins.
- IDLE:
  - If any request bit is set and portEnable=1 at an edge, go to GRANT and register the winner; cnt=0.
  - Latency is 1 cycle: request seen at edge N gives grant visible after edge N.
  - If portEnable=0, stay in IDLE and issue no grant.
- GRANT, evaluated each edge with g = grantIndex:
  - Release if request[g]==0, or if transferValid==1 and cnt==MAX_BURST-1.
  - On release:
    - ptr = (g+1) mod NUM_REQ.
    - Same edge re-arbitration from the new ptr: if any request is set and portEnable=1, grant the winner and stay in GRANT with cnt=0.
    - Otherwise go to IDLE with grant=0.
    - After a burst-limit release, g is lowest priority but is re-granted if it is the only requester.
  - Otherwise hold the grant; cnt increments only when transferValid=1.
  - portEnable=0 holds the grant and cnt frozen, with no transfer and no release; request[g]==0 still releases.
- Grant is always one-hot or zero. grantIndex always equals the encoding of grant.
- Request bits for non-granted sources may toggle freely; only the granted bit affects release.
- No request is dropped: every persistently asserted request is granted within (NUM_REQ-1)*MAX_BURST transfers plus one cycle per intervening grant.

Test Plan:
1. Reset low 2 cycles with request=5'b11111 -> grant=0, busy=0. Release reset, portEnable=1 -> after 1 edge grant=5'b00001, grantIndex=0.
2. request=5'b10101 held, portEnable=1, MAX_BURST=4 -> grant sequence N x4, E x4, LOCAL x4, N x4. No idle cycle between grants; transferValid continuously 1.
3. Grant to SOUTH (request=5'b00010); drop request[1] after 2 transfers -> grant=0 at that edge, busy=0, ptr=2. Next request=5'b00011 -> grant NORTH only after EAST/WEST/LOCAL are checked (NORTH, index 0).
4. Granted WEST; portEnable=0 for 3 cycles mid-burst -> grant stays 5'b01000, transferValid=0, cnt frozen at its value. Burst completes with 4 total transfers after re-enable.
5. Only LOCAL requesting (5'b10000) for 10 cycles -> continuous grant, re-granted at each 4-transfer boundary, 10 transfers total.
6. Reset asserted during GRANT (cnt=2) -> next edge grant=0, transferValid=0, ptr=0. After release, request=5'b11000 -> grant WEST (index 3).

Source files
------------

// File: rtl/router_port_arbiter_if.sv
// Handshake bundle between the five requesting sources and one output-port arbiter.
interface router_port_arbiter_if #(
  parameter int NUM_REQ   = 5,
  parameter int IDX_WIDTH = 3
);
  logic [NUM_REQ-1:0]   request;
  logic                 portEnable;
  logic [NUM_REQ-1:0]   grant;
  logic                 grantValid;
  logic [IDX_WIDTH-1:0] grantIndex;
  logic                 transferValid;
  logic                 busy;

  modport master (
    output request, portEnable,
    input  grant, grantValid, grantIndex, transferValid, busy
  );

  modport slave (
    input  request, portEnable,
    output grant, grantValid, grantIndex, transferValid, busy
  );
endinterface

// File: rtl/router_port_arbiter.sv
// Round-robin arbiter for one router output port: bounded bursts per grant and
// same-edge re-arbitration on release so consecutive grants have no bubble.
module router_port_arbiter #(
  parameter int NUM_REQ   = 5,
  parameter int MAX_BURST = 4,
  parameter int IDX_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  router_port_arbiter_if.slave   bus
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic [3:0]           cnt_q, cnt_d;

  logic                 xfer;
  logic                 release_now;
  logic                 win_found;
  logic [IDX_WIDTH-1:0] win_idx;
  logic [IDX_WIDTH-1:0] search_ptr;

  function automatic logic [IDX_WIDTH-1:0] wrap_inc(input logic [IDX_WIDTH-1:0] c);
    return (c == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : c + 1'b1;
  endfunction

  // First set request bit at or after start, wrapping modulo NUM_REQ.
  function automatic logic [IDX_WIDTH:0] pick(input logic [NUM_REQ-1:0]   req,
                                              input logic [IDX_WIDTH-1:0] start);
    logic                 found;
    logic [IDX_WIDTH-1:0] idx;
    logic [IDX_WIDTH-1:0] c;
    found = 1'b0;
    idx   = '0;
    c     = start;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = c;
      end
      c = wrap_inc(c);
    end
    return {found, idx};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign xfer        = (|grant_q) & bus.request[idx_q] & bus.portEnable;
  assign release_now = !bus.request[idx_q] || (xfer && cnt_q == 4'(MAX_BURST - 1));
  // On release the search restarts just past the outgoing winner.
  assign search_ptr  = (state_q == S_GRANT) ? wrap_inc(idx_q) : ptr_q;
  assign {win_found, win_idx} = pick(bus.request, search_ptr);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_found && bus.portEnable) begin
          state_d = S_GRANT;
          grant_d = NUM_REQ'(1) << win_idx;
          idx_d   = win_idx;
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        if (release_now) begin
          ptr_d = search_ptr;
          cnt_d = '0;
          if (win_found && bus.portEnable) begin
            grant_d = NUM_REQ'(1) << win_idx;
            idx_d   = win_idx;
          end else begin
            state_d = S_IDLE;
            grant_d = '0;
            idx_d   = '0;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    bus.grant         = grant_q;
    bus.grantValid    = |grant_q;
    bus.grantIndex    = idx_q;
    bus.transferValid = xfer;
    bus.busy          = (state_q == S_GRANT);
  end

endmodule

// File: tb/tb_router_port_arbiter.sv
// Randomized and directed stimulus for router_port_arbiter, checked every cycle
// against a behavioural model of the round-robin burst rules.
module tb_router_port_arbiter;
  localparam int NR = 5;
  localparam int MB = 4;
  localparam int IW = 3;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  // behavioural model: granted source (-1 when idle), pointer, transfers in burst
  int   m_g;
  int   m_ptr;
  int   m_cnt;

  logic [NR-1:0] last_grant;
  logic [IW-1:0] last_idx;
  logic          last_tv;

  router_port_arbiter_if #(.NUM_REQ(NR), .IDX_WIDTH(IW)) ifc ();

  router_port_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .IDX_WIDTH(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_src(input logic [NR-1:0] req, input int start);
    for (int i = 0; i < NR; i++) begin
      if (req[(start + i) % NR]) return (start + i) % NR;
    end
    return -1;
  endfunction

  task automatic model_edge(input bit rn, input logic [NR-1:0] req, input bit pe);
    int w;
    bit tv;
    if (!rn) begin
      m_g = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_g < 0) begin
      w = pick_src(req, m_ptr);
      if (w >= 0 && pe) begin
        m_g = w; m_cnt = 0;
      end
    end else begin
      tv = req[m_g] && pe;
      if (!req[m_g] || (tv && m_cnt == MB - 1)) begin
        m_ptr = (m_g + 1) % NR;
        m_cnt = 0;
        w = pick_src(req, m_ptr);
        if (w >= 0 && pe) m_g = w;
        else m_g = -1;
      end else if (tv) begin
        m_cnt++;
      end
    end
  endtask

  // Drive one cycle's inputs, compare outputs with the model, then advance the model.
  task automatic step(input bit rn, input logic [NR-1:0] req, input bit pe);
    logic [NR-1:0] eg;
    logic [IW-1:0] ei;
    bit            etv;
    @(negedge clk);
    reset = rn;
    ifc.request = req;
    ifc.portEnable = pe;
    #1;
    eg  = (m_g < 0) ? '0 : NR'(1 << m_g);
    ei  = (m_g < 0) ? '0 : IW'(m_g);
    etv = (m_g >= 0) && req[m_g] && pe;
    chk("grant",         32'(ifc.grant),         32'(eg));
    chk("grantIndex",    32'(ifc.grantIndex),    32'(ei));
    chk("grantValid",    32'(ifc.grantValid),    32'(m_g >= 0));
    chk("transferValid", 32'(ifc.transferValid), 32'(etv));
    chk("busy",          32'(ifc.busy),          32'(m_g >= 0));
    last_grant = ifc.grant;
    last_idx   = ifc.grantIndex;
    last_tv    = ifc.transferValid;
    model_edge(rn, req, pe);
    @(posedge clk);
  endtask

  initial begin
    int tcnt;
    int seq [4];
    logic [NR-1:0] rq;
    bit pe;
    bit rn;
    checks = 0; failures = 0;
    m_g = -1; m_ptr = 0; m_cnt = 0;
    seq[0] = 0; seq[1] = 2; seq[2] = 4; seq[3] = 0;

    // reset held with every source requesting
    reset = 1'b0;
    ifc.request = 5'b11111;
    ifc.portEnable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(ifc.grant), 32'd0);
    chk("rst_busy",  32'(ifc.busy),  32'd0);
    step(1, 5'b11111, 1);
    #1;
    chk("t1_grant", 32'(ifc.grant), 32'b00001);
    chk("t1_idx",   32'(ifc.grantIndex), 32'd0);

    // N, E, LOCAL, N bursts of four with no gap
    step(0, 5'b00000, 1);
    step(1, 5'b10101, 1);
    for (int k = 0; k < 16; k++) begin
      step(1, 5'b10101, 1);
      chk("t2_idx", 32'(last_idx), 32'(seq[k / 4]));
      chk("t2_tv",  32'(last_tv),  32'd1);
    end

    // SOUTH drops its request after two transfers
    step(0, 5'b00000, 1);
    step(1, 5'b00010, 1);
    step(1, 5'b00010, 1);
    step(1, 5'b00010, 1);
    step(1, 5'b00000, 1);
    #1;
    chk("t3_grant", 32'(ifc.grant), 32'd0);
    chk("t3_busy",  32'(ifc.busy),  32'd0);
    step(1, 5'b00011, 1);
    #1;
    chk("t3_regrant", 32'(ifc.grant), 32'b00001);

    // WEST stalled by portEnable mid-burst
    step(0, 5'b00000, 1);
    step(1, 5'b01000, 1);
    tcnt = 0;
    step(1, 5'b01000, 1); tcnt += int'(last_tv);
    for (int k = 0; k < 3; k++) begin
      step(1, 5'b01000, 0);
      chk("t4_hold_grant", 32'(last_grant), 32'b01000);
      chk("t4_hold_tv",    32'(last_tv),    32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      step(1, 5'b01000, 1); tcnt += int'(last_tv);
    end
    chk("t4_transfers", 32'(tcnt), 32'd4);

    // lone LOCAL requester is re-granted across burst boundaries
    step(0, 5'b00000, 1);
    step(1, 5'b10000, 1);
    tcnt = 0;
    for (int k = 0; k < 10; k++) begin
      step(1, 5'b10000, 1); tcnt += int'(last_tv);
    end
    chk("t5_transfers", 32'(tcnt), 32'd10);

    // reset arriving mid-burst
    step(0, 5'b00000, 1);
    step(1, 5'b11111, 1);
    step(1, 5'b11111, 1);
    step(1, 5'b11111, 1);
    step(0, 5'b11111, 1);
    #1;
    chk("t6_grant", 32'(ifc.grant), 32'd0);
    chk("t6_tv",    32'(ifc.transferValid), 32'd0);
    step(1, 5'b11000, 1);
    #1;
    chk("t6_idx", 32'(ifc.grantIndex), 32'd3);

    // randomized traffic with mostly persistent requests
    rq = 5'b00000;
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < NR; b++) begin
        if ($urandom_range(7) == 0) rq[b] = ~rq[b];
      end
      pe = ($urandom_range(7) != 0);
      rn = ($urandom_range(199) != 0);
      step(rn, rq, pe);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
